// File: rtl/johnson_rx_checker.sv
// Receive-side Johnson code checker: decodes each sample to its sequence index,
// validates the code and its succession, locks on clean runs, counts errors.
module johnson_rx_checker #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WIDTH-1:0]            din,
   input  logic                        din_valid,
   output logic [$clog2(2*WIDTH)-1:0]  bin_out,
   output logic                        bin_valid,
   output logic                        locked,
   output logic                        seq_err,
   output logic                        wrap,
   output logic [ERR_W-1:0]            err_count
);
   localparam int IW = $clog2(2*WIDTH);
   localparam int PW = $clog2(WIDTH+1);
   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ONE_E    = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0]    LAST_IDX = IW'(2*WIDTH-1);
   localparam logic [4:0]       LOCK_V   = 5'(LOCK_CNT);

   typedef enum logic [0:0] {S_HUNT = 1'b0, S_LOCKED = 1'b1} state_t;

   function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [PW-1:0] cnt;
      cnt = {PW{1'b0}};
      for (int i = 0; i < WIDTH; i++) cnt = cnt + PW'(v[i]);
      return cnt;
   endfunction

   // A legal code, after folding the MSB=1 half, is a run of ones from the LSB.
   function automatic logic is_legal(input logic [WIDTH-1:0] c);
      logic [WIDTH-1:0] v;
      v = c[WIDTH-1] ? ~c : c;
      return ((v & (v + ONE_W)) == {WIDTH{1'b0}});
   endfunction

   function automatic logic [IW-1:0] decode(input logic [WIDTH-1:0] c);
      logic [IW:0] pc;
      pc = (IW+1)'(popcount(c));
      if (c[WIDTH-1]) return IW'((IW+1)'(2*WIDTH) - pc);
      else            return IW'(pc);
   endfunction

   function automatic logic [WIDTH-1:0] successor(input logic [WIDTH-1:0] c);
      return {c[WIDTH-2:0], ~c[WIDTH-1]};
   endfunction

   state_t           state_r, state_nx_s;
   logic [3:0]       match_cnt_r, match_nx_s;
   logic             prev_valid_r, prev_valid_nx_s;
   logic [WIDTH-1:0] prev_code_r, prev_code_nx_s;
   logic [IW-1:0]    bin_out_r, bin_out_nx_s;
   logic             bin_valid_r, bin_valid_nx_s;
   logic             locked_r, locked_nx_s;
   logic             seq_err_r, seq_err_nx_s;
   logic             wrap_r, wrap_nx_s;
   logic [ERR_W-1:0] err_count_r, err_nx_s, err_inc_s;
   logic             legal_s, succ_ok_s;
   logic [IW-1:0]    idx_s;
   logic [4:0]       match_inc_s;

   assign legal_s     = is_legal(din);
   assign idx_s       = decode(din);
   assign succ_ok_s   = prev_valid_r && (din == successor(prev_code_r));
   assign match_inc_s = {1'b0, match_cnt_r} + 5'd1;
   assign err_inc_s   = (err_count_r == {ERR_W{1'b1}}) ? err_count_r : err_count_r + ONE_E;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= S_HUNT;
      else     state_r <= state_nx_s;
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      if (!din_valid) begin
         state_nx_s = state_r;
      end else if (!legal_s) begin
         state_nx_s = S_HUNT;
      end else begin
         case (state_r)
            S_HUNT:   if (succ_ok_s && (match_inc_s >= LOCK_V)) state_nx_s = S_LOCKED;
                      else                                     state_nx_s = S_HUNT;
            S_LOCKED: if (succ_ok_s) state_nx_s = S_LOCKED;
                      else           state_nx_s = S_HUNT;
            default:  state_nx_s = S_HUNT;
         endcase
      end
   end

   // Output and tracking next values; pulses default low
   always_comb begin
      match_nx_s      = match_cnt_r;
      prev_valid_nx_s = prev_valid_r;
      prev_code_nx_s  = prev_code_r;
      bin_out_nx_s    = bin_out_r;
      bin_valid_nx_s  = 1'b0;
      seq_err_nx_s    = 1'b0;
      wrap_nx_s       = 1'b0;
      err_nx_s        = err_count_r;
      locked_nx_s     = (state_nx_s == S_LOCKED);
      if (!din_valid) begin
         match_nx_s = match_cnt_r;
      end else if (!legal_s) begin
         seq_err_nx_s    = 1'b1;
         err_nx_s        = err_inc_s;
         match_nx_s      = 4'd0;
         prev_valid_nx_s = 1'b0;
      end else begin
         bin_out_nx_s    = idx_s;
         bin_valid_nx_s  = 1'b1;
         prev_code_nx_s  = din;
         prev_valid_nx_s = 1'b1;
         case (state_r)
            S_HUNT: begin
               if (succ_ok_s) match_nx_s = match_inc_s[3:0];
               else           match_nx_s = 4'd0;
            end
            S_LOCKED: begin
               if (succ_ok_s) begin
                  wrap_nx_s = (decode(prev_code_r) == LAST_IDX) && (idx_s == {IW{1'b0}});
               end else begin
                  seq_err_nx_s = 1'b1;
                  err_nx_s     = err_inc_s;
                  match_nx_s   = 4'd0;
               end
            end
            default: match_nx_s = 4'd0;
         endcase
      end
   end

   // Tracking and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_cnt_r  <= 4'd0;
         prev_valid_r <= 1'b0;
         prev_code_r  <= {WIDTH{1'b0}};
         bin_out_r    <= {IW{1'b0}};
         bin_valid_r  <= 1'b0;
         locked_r     <= 1'b0;
         seq_err_r    <= 1'b0;
         wrap_r       <= 1'b0;
         err_count_r  <= {ERR_W{1'b0}};
      end else begin
         match_cnt_r  <= match_nx_s;
         prev_valid_r <= prev_valid_nx_s;
         prev_code_r  <= prev_code_nx_s;
         bin_out_r    <= bin_out_nx_s;
         bin_valid_r  <= bin_valid_nx_s;
         locked_r     <= locked_nx_s;
         seq_err_r    <= seq_err_nx_s;
         wrap_r       <= wrap_nx_s;
         err_count_r  <= err_nx_s;
      end
   end

   assign bin_out   = bin_out_r;
   assign bin_valid = bin_valid_r;
   assign locked    = locked_r;
   assign seq_err   = seq_err_r;
   assign wrap      = wrap_r;
   assign err_count = err_count_r;
endmodule

// File: tb/tb_johnson_rx_checker.sv
// Directed bench for johnson_rx_checker (WIDTH=4, LOCK_CNT=3, ERR_W=8).
module tb_johnson_rx_checker;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] din = 4'h0;
   logic       din_valid = 1'b0;
   logic [2:0] bin_out;
   logic       bin_valid, locked, seq_err, wrap;
   logic [7:0] err_count;

   int n_chk  = 0;
   int n_fail = 0;

   logic [3:0] seq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
   logic [3:0] ill [8] = '{4'h2, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA, 4'hB, 4'hD};

   johnson_rx_checker #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked),
      .seq_err(seq_err), .wrap(wrap), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [3:0] d, input logic v);
      din = d;
      din_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic outs(input string tag, input int bo, input int bv, input int lk,
                       input int se, input int wr, input int ec);
      check({tag, ".bin_out"},   32'(bin_out),   32'(bo));
      check({tag, ".bin_valid"}, 32'(bin_valid), 32'(bv));
      check({tag, ".locked"},    32'(locked),    32'(lk));
      check({tag, ".seq_err"},   32'(seq_err),   32'(se));
      check({tag, ".wrap"},      32'(wrap),      32'(wr));
      check({tag, ".err_count"}, 32'(err_count), 32'(ec));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      outs("reset", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // Clean sequence 0..7,0: lock on the 4th sample, wrap on the final 0000
      for (int i = 0; i < 9; i++) begin
         step(seq[i % 8], 1'b1);
         outs($sformatf("clean%0d", i), i % 8, 1, (i >= 3) ? 1 : 0, 0, (i == 8) ? 1 : 0, 0);
      end

      // Illegal code while locked, then relock from 1100
      step(4'h5, 1'b1);  outs("ill0101", 0, 0, 0, 1, 0, 1);
      step(4'hC, 1'b1);  outs("res1100", 6, 1, 0, 0, 0, 1);
      step(4'h8, 1'b1);  outs("res1000", 7, 1, 0, 0, 0, 1);
      step(4'h0, 1'b1);  outs("res0000", 0, 1, 0, 0, 0, 1);
      step(4'h1, 1'b1);  outs("res0001", 1, 1, 1, 0, 0, 1);

      // Legal wrong successor while locked
      step(4'h3, 1'b1);  outs("lk0011",  2, 1, 1, 0, 0, 1);
      step(4'hE, 1'b1);  outs("wr1110",  5, 1, 0, 1, 0, 2);
      step(4'hC, 1'b1);  outs("wr1100",  6, 1, 0, 0, 0, 2);
      step(4'h8, 1'b1);  outs("wr1000",  7, 1, 0, 0, 0, 2);
      step(4'h0, 1'b1);  outs("wr0000",  0, 1, 1, 0, 0, 2);

      // Repeated code while locked is an error; then relock from that reference
      step(4'h0, 1'b1);  outs("rep0000", 0, 1, 0, 1, 0, 3);
      step(4'h1, 1'b1);  outs("rep0001", 1, 1, 0, 0, 0, 3);
      step(4'h3, 1'b1);  outs("rep0011", 2, 1, 0, 0, 0, 3);
      step(4'h7, 1'b1);  outs("rep0111", 3, 1, 1, 0, 0, 3);
      step(4'hF, 1'b1);  outs("rep1111", 4, 1, 1, 0, 0, 3);

      // Asynchronous reset between clock edges
      #2 rst = 1'b1;
      #1;
      outs("async", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // Alternate valid and idle cycles from a fresh reference
      for (int k = 0; k < 4; k++) begin
         step(seq[k], 1'b1);
         outs($sformatf("tgl_v%0d", k), k, 1, (k == 3) ? 1 : 0, 0, 0, 0);
         step(4'h5, 1'b0);
         outs($sformatf("tgl_i%0d", k), k, 0, (k == 3) ? 1 : 0, 0, 0, 0);
      end

      // Error counter saturation over 300 illegal samples
      for (int i = 0; i < 300; i++) begin
         step(ill[i % 8], 1'b1);
         if (i < 8) begin
            check($sformatf("ill%0d.seq_err", i), 32'(seq_err), 32'd1);
            check($sformatf("ill%0d.bin_valid", i), 32'(bin_valid), 32'd0);
         end
         if (i == 253) check("sat.err254", 32'(err_count), 32'd254);
      end
      outs("sat.end", 3, 0, 0, 1, 0, 255);
      step(4'h5, 1'b0);
      outs("sat.idle", 3, 0, 0, 0, 0, 255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/johnson_rx_checker.md
Name: johnson_rx_checker

Overview:
Receive-side companion to the Johnson counter. It samples a WIDTH-bit Johnson-coded bus and decodes each sample to its binary sequence index. It also checks that every sample is a legal code, and that each sample is the correct successor of the previous one. It locks onto a clean sequence, flags sequence errors, keeps a saturating error count, and pulses on each full-cycle wrap.

Parameters:
WIDTH, 4, number of Johnson code bits; sequence length is 2*WIDTH.
LOCK_CNT, 3, consecutive correct successors needed to go from HUNT to LOCKED (range 1..15).
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
din  input  WIDTH  Johnson-coded sample.
din_valid  input  1  din is sampled on this rising edge.
bin_out  output  $clog2(2*WIDTH)  decoded index of the last legal sample.
bin_valid  output  1  one-cycle pulse: bin_out was updated from a legal sample.
locked  output  1  checker is in LOCKED state.
seq_err  output  1  one-cycle pulse: illegal code, or wrong successor while LOCKED.
wrap  output  1  one-cycle pulse while LOCKED: sequence stepped from index 2*WIDTH-1 to 0.
err_count  output  ERR_W  count of seq_err pulses; saturates at all-ones.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; clock port is clk, reset port is rst.
- Reset values:
  - bin_out=0, bin_valid=0, locked=0, seq_err=0, wrap=0, err_count=0.
  - State=HUNT, match_cnt=0, prev_valid=0.
- Sequence definition: successor of code c is {c[WIDTH-2:0], ~c[WIDTH-1]}. For WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000,0000.
- Legal code:
  - MSB=0: din must be of the form 2^k-1 (k=0..WIDTH-1).
  - MSB=1: ~din must be of the form 2^k-1.
  - All other codes are illegal (for WIDTH=4: 8 legal, 8 illegal).
- Decode: index = MSB ? (2*WIDTH - popcount(din)) : popcount(din).
- Latency and outputs:
  - All outputs are registered; response appears on the clock edge after the sampling edge (1-cycle latency).
  - bin_valid, seq_err and wrap are single-cycle pulses.
- din_valid=0 cycle:
  - No state change; bin_out, locked and err_count hold.
  - bin_valid, seq_err and wrap all drive 0.
- State HUNT, legal sample:
  - bin_out=index, bin_valid=1.
  - If prev_valid and din equals the successor of the previous code: match_cnt++. Otherwise match_cnt=0 and the sample becomes the new reference.
  - Sample is stored as the previous code; prev_valid=1.
  - When match_cnt reaches LOCK_CNT: state=LOCKED, locked=1 on the same output edge.
  - A wrong successor in HUNT is not an error.
- State LOCKED, legal correct successor: bin_out=index, bin_valid=1. wrap=1 if the previous index was 2*WIDTH-1 and the new index is 0.
- State LOCKED, legal wrong successor (including a repeated code):
  - seq_err=1, err_count++.
  - bin_out=index, bin_valid=1.
  - state=HUNT, locked=0, match_cnt=0; the sample becomes the new reference.
- Illegal code, in any state:
  - seq_err=1, err_count++.
  - bin_valid=0, bin_out holds.
  - state=HUNT, locked=0, match_cnt=0, prev_valid=0.
- err_count saturation: saturates at 2^ERR_W-1 and is cleared only by rst.
- Reset mid-operation: immediately restores all reset values, regardless of clock; the first sample after release is treated as a fresh reference.

Test Plan:
- Reset, then feed the clean sequence from 0000 with din_valid=1 every cycle:
  - bin_out 0,1,2,3,...,7,0.
  - locked rises on the output for 0111 (4th sample).
  - wrap=1 exactly on the 0000 following 1000.
  - err_count=0.
- While LOCKED, inject 0101 (illegal):
  - seq_err=1, bin_valid=0, bin_out holds, locked=0, err_count=1.
  - Then resume at 1100: relocks after LOCK_CNT more correct successors.
- While LOCKED after 0011, send 1110 (legal, wrong):
  - seq_err=1, bin_out=5, locked=0, err_count increments.
  - Following 1100: match_cnt=1, no error.
- Toggle din_valid 1/0 over the clean sequence:
  - Outputs update only after valid edges; pulses are 0 on idle cycles.
  - Lock is reached after 4 valid samples.
- Apply 300 illegal samples with ERR_W=8: err_count stops at 255.
- Assert rst asynchronously mid-sequence while LOCKED: all outputs go to 0 before the next clk edge.
